// File: rtl/cpu_clk_ctrl.sv
// cpu_clk_ctrl - CPU clock-enable controller for the 100 MHz board clock.
//
// Generates a one-cycle cpu_ce pulse at a selectable decade/binary rate and
// sequences the CPU through STOP / RUN / single-STEP / HALT from a run switch,
// a step button and a halt request from the CPU itself.
//
// Optional feature macro: CPU_CLK_CTRL_CYCCNT_EN
//   defined   : cyc_cnt counts every issued cpu_ce pulse (wraps, reset-only clear)
//   undefined : cyc_cnt is tied to zero and no counter is built
module cpu_clk_ctrl #(
    parameter int DIV_W       = 27,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  sel,
    input  logic        run_sw,
    input  logic        step_btn,
    input  logic        halt,
    output logic        cpu_ce,
    output logic        running,
    output logic        halted,
    output logic [1:0]  state,
    output logic [31:0] cyc_cnt
);

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    // Terminal count (N-1) of the prescaler for a given rate select.
    // Selects above 11 saturate at the slowest rate (1 Hz).
    function automatic logic [DIV_W-1:0] div_last(input logic [3:0] s);
        logic [31:0] v;
        case (s)
            4'd0:    v = 32'd0;
            4'd1:    v = 32'd1;
            4'd2:    v = 32'd3;
            4'd3:    v = 32'd4;
            4'd4:    v = 32'd9;
            4'd5:    v = 32'd99;
            4'd6:    v = 32'd999;
            4'd7:    v = 32'd9_999;
            4'd8:    v = 32'd99_999;
            4'd9:    v = 32'd999_999;
            4'd10:   v = 32'd9_999_999;
            default: v = 32'd99_999_999;
        endcase
        return DIV_W'(v);
    endfunction

    logic [DIV_W-1:0]       cnt_r;
    logic [3:0]             sel_q_r;
    logic [SYNC_STAGES-1:0] run_sync_r;
    logic [SYNC_STAGES-1:0] step_sync_r;
    logic                   step_dly_r;
    state_t                 state_r;
    state_t                 state_nxt_s;

    logic [DIV_W-1:0]       cnt_last_s;
    logic                   sel_change_s;
    logic                   tick_s;
    logic                   run_s;
    logic                   step_edge_s;

    assign cnt_last_s   = div_last(sel_q_r);
    assign sel_change_s = (sel != sel_q_r);
    // A pending rate change suppresses the tick so no pulse is issued at a
    // half-old/half-new rate.
    assign tick_s       = (cnt_r == cnt_last_s) && !sel_change_s;

    assign run_s        = run_sync_r[SYNC_STAGES-1];
    assign step_edge_s  = step_sync_r[SYNC_STAGES-1] & ~step_dly_r;

    // Prescaler counter and registered rate select; restarts on a rate change.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r   <= '0;
            sel_q_r <= sel;
        end else if (sel_change_s) begin
            cnt_r   <= '0;
            sel_q_r <= sel;
        end else if (cnt_r == cnt_last_s) begin
            cnt_r   <= '0;
        end else begin
            cnt_r   <= cnt_r + 1'b1;
        end
    end

    // Metastability synchronizers for the switch and button, plus the delay
    // flop used to find the button's rising edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            run_sync_r  <= '0;
            step_sync_r <= '0;
            step_dly_r  <= 1'b0;
        end else begin
            run_sync_r  <= {run_sync_r[SYNC_STAGES-2:0], run_sw};
            step_sync_r <= {step_sync_r[SYNC_STAGES-2:0], step_btn};
            step_dly_r  <= step_sync_r[SYNC_STAGES-1];
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_STOP;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Sequencer next-state logic. Run beats step in STOP, halt beats the
    // switch in RUN, and a STEP always finishes its single pulse.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_STOP: begin
                if (run_s) begin
                    state_nxt_s = ST_RUN;
                end else if (step_edge_s) begin
                    state_nxt_s = ST_STEP;
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            ST_RUN: begin
                if (halt) begin
                    state_nxt_s = ST_HALT;
                end else if (!run_s) begin
                    state_nxt_s = ST_STOP;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_STEP: begin
                if (tick_s) begin
                    state_nxt_s = ST_STOP;
                end else begin
                    state_nxt_s = ST_STEP;
                end
            end
            ST_HALT: begin
                if (!run_s) begin
                    state_nxt_s = ST_STOP;
                end else begin
                    state_nxt_s = ST_HALT;
                end
            end
            default: begin
                state_nxt_s = ST_STOP;
            end
        endcase
    end

    assign cpu_ce  = tick_s && ((state_r == ST_RUN) || (state_r == ST_STEP));
    assign running = (state_r == ST_RUN);
    assign halted  = (state_r == ST_HALT);
    assign state   = state_r;

`ifdef CPU_CLK_CTRL_CYCCNT_EN
    logic [31:0] cyc_cnt_r;

    // Count of issued CPU cycles; wraps naturally at 32 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_cnt_r <= 32'd0;
        end else if (cpu_ce) begin
            cyc_cnt_r <= cyc_cnt_r + 32'd1;
        end else begin
            cyc_cnt_r <= cyc_cnt_r;
        end
    end

    assign cyc_cnt = cyc_cnt_r;
`else
    assign cyc_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// tb_cpu_clk_ctrl - directed, table-driven bench for cpu_clk_ctrl.
// Inputs change 1 time unit after the rising edge; outputs are compared on
// the falling edge, i.e. with the registers as left by the previous edge.
module tb_cpu_clk_ctrl;

    logic        clk;
    logic        reset;
    logic [3:0]  sel;
    logic        run_sw;
    logic        step_btn;
    logic        halt;
    logic        cpu_ce;
    logic        running;
    logic        halted;
    logic [1:0]  state;
    logic [31:0] cyc_cnt;

    int n_vec  = 0;
    int n_miss = 0;

    cpu_clk_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .sel      (sel),
        .run_sw   (run_sw),
        .step_btn (step_btn),
        .halt     (halt),
        .cpu_ce   (cpu_ce),
        .running  (running),
        .halted   (halted),
        .state    (state),
        .cyc_cnt  (cyc_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] sel;
        logic       run;
        logic       step;
        logic       halt;
        logic       ce;
        logic [1:0] st;
    } vec_t;

    vec_t tbl [25];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    // From pos+1: advance until cpu_ce is seen; returns at that falling edge.
    task automatic wait_ce(input int limit, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < limit; k++) begin
            to_neg();
            if (cpu_ce === 1'b1) begin
                ok = 1'b1;
                break;
            end
            to_pos();
        end
    endtask

    // From a falling edge with cpu_ce high: cycles until the next pulse.
    task automatic measure_gap(output int gap);
        gap = 0;
        for (int k = 1; k <= 40; k++) begin
            to_pos();
            to_neg();
            if (cpu_ce === 1'b1) begin
                gap = k;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  exp_cyc;
        int  gap;
        int  pulses;
        int  bad;
        bit  ok;

        // rst sel run step halt | ce st
        tbl[0]  = '{1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
        tbl[1]  = '{1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
        tbl[2]  = '{1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
        tbl[3]  = '{1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
        tbl[4]  = '{1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1};
        tbl[5]  = '{1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1};
        tbl[6]  = '{1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1};
        tbl[7]  = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1};
        tbl[8]  = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1};
        tbl[9]  = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1};
        tbl[10] = '{1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1};
        tbl[11] = '{1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1};
        tbl[12] = '{1'b0, 4'd1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1};
        tbl[13] = '{1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3};
        tbl[14] = '{1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3};
        tbl[15] = '{1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3};
        tbl[16] = '{1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3};
        tbl[17] = '{1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3};
        tbl[18] = '{1'b0, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0};
        tbl[19] = '{1'b0, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0};
        tbl[20] = '{1'b0, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0};
        tbl[21] = '{1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2};
        tbl[22] = '{1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2};
        tbl[23] = '{1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
        tbl[24] = '{1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};

        // Initial reset, sel = 1
        reset = 1'b1; sel = 4'd1; run_sw = 1'b0; step_btn = 1'b0; halt = 1'b0;
        to_pos();
        to_pos();

        // Table: run at N=2, N=1, rate-change suppression, halt, single step
        exp_cyc = 0;
        for (int i = 0; i < 25; i++) begin
            reset = tbl[i].rst; sel = tbl[i].sel; run_sw = tbl[i].run;
            step_btn = tbl[i].step; halt = tbl[i].halt;
            to_neg();
            check($sformatf("tbl%0d_ce", i), {31'd0, cpu_ce}, {31'd0, tbl[i].ce});
            check($sformatf("tbl%0d_state", i), {30'd0, state}, {30'd0, tbl[i].st});
            check($sformatf("tbl%0d_running", i), {31'd0, running}, {31'd0, tbl[i].st == 2'd1});
            check($sformatf("tbl%0d_halted", i), {31'd0, halted}, {31'd0, tbl[i].st == 2'd3});
`ifdef CPU_CLK_CTRL_CYCCNT_EN
            check($sformatf("tbl%0d_cyc", i), cyc_cnt, exp_cyc);
`else
            check($sformatf("tbl%0d_cyc", i), cyc_cnt, 32'd0);
`endif
            if (!tbl[i].rst && tbl[i].ce) exp_cyc++;
            to_pos();
        end
        halt = 1'b0; step_btn = 1'b0;

        // S1: reset with sel=4 and run held -> RUN two edges after first sample, period 10
        reset = 1'b1; sel = 4'd4; run_sw = 1'b1;
        to_pos();
        reset = 1'b0;
        to_neg();
        check("s1_reset_state", {30'd0, state}, 32'd0);
        check("s1_reset_ce", {31'd0, cpu_ce}, 32'd0);
        check("s1_reset_cyc", cyc_cnt, 32'd0);
        to_pos();
        to_pos();
        to_neg();
        check("s1_pre_run", {30'd0, state}, 32'd0);
        to_pos();
        to_neg();
        check("s1_run", {30'd0, state}, 32'd1);
        to_pos();
        wait_ce(30, ok);
        check("s1_first_ce_seen", {31'd0, ok}, 32'd1);
        measure_gap(gap);
        check("s1_period_a", gap, 32'd10);
        measure_gap(gap);
        check("s1_period_b", gap, 32'd10);

        // S2: sel=0 -> every cycle; sel=3 -> first pulse 5 cycles after update
        to_pos();
        sel = 4'd0;
        to_neg();
        check("s2_mismatch0", {31'd0, cpu_ce}, 32'd0);
        to_pos();
        for (int i = 0; i < 4; i++) begin
            to_neg();
            check($sformatf("s2_n1_c%0d", i), {31'd0, cpu_ce}, 32'd1);
            to_pos();
        end
        sel = 4'd3;
        to_neg();
        check("s2_mismatch3", {31'd0, cpu_ce}, 32'd0);
        to_pos();
        for (int i = 1; i <= 5; i++) begin
            to_neg();
            check($sformatf("s2_n5_c%0d", i), {31'd0, cpu_ce}, {31'd0, i == 5});
            if (i < 5) to_pos();
        end
        measure_gap(gap);
        check("s2_period_a", gap, 32'd5);
        measure_gap(gap);
        check("s2_period_b", gap, 32'd5);

        // S3: three 20-cycle step presses, 50 apart, at sel=2
        to_pos();
        reset = 1'b1; sel = 4'd2; run_sw = 1'b0;
        to_pos();
        reset = 1'b0;
        pulses = 0;
        for (int p = 0; p < 3; p++) begin
            step_btn = 1'b1;
            for (int c = 0; c < 50; c++) begin
                if (c == 20) step_btn = 1'b0;
                to_neg();
                if (cpu_ce === 1'b1) pulses++;
                to_pos();
            end
            to_neg();
            check($sformatf("s3_stop_%0d", p), {30'd0, state}, 32'd0);
            to_pos();
        end
        check("s3_pulses", pulses, 32'd3);
`ifdef CPU_CLK_CTRL_CYCCNT_EN
        check("s3_cyc", cyc_cnt, 32'd3);
`else
        check("s3_cyc", cyc_cnt, 32'd0);
`endif

        // S4: run, one-cycle halt, no pulses, switch off then on
        run_sw = 1'b1;
        to_pos(); to_pos(); to_pos();
        to_neg();
        check("s4_run", {30'd0, state}, 32'd1);
        check("s4_running", {31'd0, running}, 32'd1);
        to_pos();
        halt = 1'b1;
        to_pos();
        halt = 1'b0;
        to_neg();
        check("s4_halt_state", {30'd0, state}, 32'd3);
        check("s4_halted", {31'd0, halted}, 32'd1);
        check("s4_not_running", {31'd0, running}, 32'd0);
        to_pos();
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            to_neg();
            if (cpu_ce === 1'b1 || state !== 2'd3) pulses++;
            to_pos();
        end
        check("s4_halt_quiet", pulses, 32'd0);
        run_sw = 1'b0;
        to_pos(); to_pos(); to_pos();
        to_neg();
        check("s4_stop", {30'd0, state}, 32'd0);
        to_pos();
        run_sw = 1'b1;
        to_pos(); to_pos(); to_pos();
        to_neg();
        check("s4_rerun", {30'd0, state}, 32'd1);
        to_pos();

        // S5: reset in the middle of a slow (sel=11) step
        run_sw = 1'b0;
        to_pos(); to_pos(); to_pos();
        sel = 4'd11; step_btn = 1'b1;
        to_pos(); to_pos(); to_pos();
        to_neg();
        check("s5_step", {30'd0, state}, 32'd2);
        to_pos();
        reset = 1'b1; step_btn = 1'b0;
        to_pos();
        to_neg();
        check("s5_rst_state", {30'd0, state}, 32'd0);
        check("s5_rst_ce", {31'd0, cpu_ce}, 32'd0);
        check("s5_rst_cnt", 32'(dut.cnt_r), 32'd0);
        to_pos();
        reset = 1'b0;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            to_neg();
            if (cpu_ce === 1'b1 || state !== 2'd0) bad++;
            to_pos();
        end
        check("s5_no_step", bad, 32'd0);

        // S6: run and step rise together in STOP -> RUN, never STEP
        sel = 4'd0;
        to_pos(); to_pos();
        run_sw = 1'b1; step_btn = 1'b1;
        bad = 0;
        for (int i = 1; i <= 3; i++) begin
            to_pos();
            to_neg();
            check($sformatf("s6_state_e%0d", i), {30'd0, state}, (i == 3) ? 32'd1 : 32'd0);
        end
        for (int c = 0; c < 5; c++) begin
            to_pos();
            to_neg();
            if (state !== 2'd1 || cpu_ce !== 1'b1) bad++;
        end
        check("s6_run_only", bad, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/cpu_clk_ctrl.md
Name: cpu_clk_ctrl

Overview:
- Single-clock CPU clock-enable controller for the 100 MHz board clock domain.
- Replaces the ripple-divider clocking scheme with a one-cycle `cpu_ce` pulse at a selectable decade/binary rate.
- Adds RUN / STOP / single-STEP sequencing driven by a switch and a button, plus a HALT request from the CPU.
- The CPU core and its peripherals run on `clk` and qualify every state update with `cpu_ce`.

Parameters:
- DIV_W, 27, width of the prescaler counter. Must hold 99_999_999.
- SYNC_STAGES, 2, flip-flop depth of the input synchronizers for `run_sw` and `step_btn`. Legal range 2..3.

Ports:
- clk  input  1  system clock, 100 MHz.
- reset  input  1  synchronous, active-high reset.
- sel  input  4  rate select; sampled every cycle.
- run_sw  input  1  asynchronous level from the board switch; 1 = run.
- step_btn  input  1  asynchronous level from the board button; each rising edge requests one step.
- halt  input  1  synchronous halt request from the CPU, on `clk`.
- cpu_ce  output  1  one-cycle clock enable to the CPU.
- running  output  1  high while state = RUN.
- halted  output  1  high while state = HALT.
- state  output  2  0 = STOP, 1 = RUN, 2 = STEP, 3 = HALT.
- cyc_cnt  output  32  count of issued `cpu_ce` pulses (see Optional Feature).

Behaviour:
- Reset (synchronous, active-high), applied at any time including mid-STEP or mid-count:
  - state = STOP, prescaler counter = 0, sel_q = sel.
  - Synchronizer flops = 0, so no spurious step edge is seen after reset.
  - Outputs: `cpu_ce` = 0, `running` = 0, `halted` = 0, `cyc_cnt` = 0.
- Divider N from `sel_q`:
  - 0 → 1, 1 → 2, 2 → 4, 3 → 5, 4 → 10, 5 → 100, 6 → 1e3, 7 → 1e4, 8 → 1e5, 9 → 1e6, 10 → 1e7, 11 → 1e8.
  - 12..15 → 1e8.
- Prescaler:
  - `cnt` counts 0..N-1 and wraps to 0.
  - `tick` = (`cnt` == N-1), combinational from registered `cnt`.
  - N = 1 gives `tick` every cycle.
  - The prescaler runs in every state.
- Rate change:
  - If `sel` != `sel_q` at a clock edge: `cnt` <= 0, `sel_q` <= `sel`, and `tick` is forced to 0 in the cycle the mismatch is seen.
  - The first tick at the new rate occurs N cycles after the update.
- Input synchronizers:
  - `run_sw` and `step_btn` pass through SYNC_STAGES flops; `step_btn` has one extra flop for edge detection.
  - `step_edge` = synced & ~delayed.
  - With SYNC_STAGES = 2, an input first sampled high at edge k changes state at edge k+2.
- `cpu_ce` = `tick` & (state == RUN | state == STEP). Combinational from registers; never asserted in STOP or HALT.
- FSM transitions:
  - STOP → RUN when `run_s` = 1.
  - STOP → STEP when `run_s` = 0 and `step_edge` = 1.
  - RUN → STOP when `run_s` = 0.
  - RUN → HALT when `halt` = 1. `halt` takes priority over `run_s` falling in the same cycle.
  - STEP → STOP on the edge closing the cycle in which `cpu_ce` = 1, giving exactly one pulse per step. `step_edge` during STEP is ignored, not queued.
  - STEP: a `halt` = 1 in STEP also forces STOP after the pulse.
  - HALT → STOP when `run_s` = 0. HALT is never left while `run_s` = 1; the operator must toggle the switch.
  - `step_edge` in RUN or HALT is ignored.
- Simultaneous events in STOP: `run_s` = 1 and `step_edge` = 1 → RUN (run wins).

Optional Feature:
- Macro: CPU_CLK_CTRL_CYCCNT_EN.
- Defined:
  - 32-bit `cyc_cnt` increments by 1 at every edge where `cpu_ce` = 1.
  - Wraps 0xFFFFFFFF → 0.
  - Cleared only by reset.
- Undefined: `cyc_cnt` tied to 32'd0 and no counter logic is generated.

Test Plan:
- Reset, `sel` = 4, `run_sw` = 1 held → state = RUN after reset release + 2 edges; `cpu_ce` pulses every 10 cycles, one cycle wide.
- `sel` = 0 in RUN → `cpu_ce` stuck high every cycle; switching to `sel` = 3 → first pulse exactly 5 cycles after `sel_q` update, then period 5.
- STOP with `sel` = 2, three `step_btn` pulses each 20 cycles long, spaced 50 cycles → exactly 3 `cpu_ce` pulses; state returns to 0 after each; `cyc_cnt` = 3 with macro defined, 0 without.
- RUN, `halt` = 1 for 1 cycle → state = 3, `halted` = 1, no further `cpu_ce`; `run_sw` 1 → 0 → state = 0; `run_sw` 0 → 1 → state = 1.
- Reset asserted mid-STEP with `sel` = 11 → next cycle state = 0, `cpu_ce` = 0, `cnt` = 0, and no step issued after release.
- STOP, `run_sw` and `step_btn` rise on the same edge → state = RUN, no separate STEP pulse.
